diff_tx: RTL and testbench

- Serializer that drives the single-wire pulse-width link consumed by the diff_rx receiver. It takes a 26-bit code plus a one-cycle trigger and emits one frame: a sync period, 26 bit cells MSB first, a low tail, and an idle gap.
- Sits directly upstream of the receiver. Its timing parameters must match the receiver instance on the far end.

---
 rtl/diff_tx.sv | 159 +++++++++++++++
 tb/tb_diff_tx.sv | 127 ++++++++++++
 2 files changed

// File: rtl/diff_tx.sv
// rtl/diff_tx.sv - pulse-width serial link transmitter (sync, 26 bit cells MSB first, tail, gap)
//
// Ports:
//   clk_in      system clock, all logic on posedge
//   rst_n_in    asynchronous active-low reset
//   code_in     26-bit code, latched on an accepted trigger
//   trigger_in  start request, honoured only in IDLE
//   data_out    registered serial line, idles high
//   busy_out    high from trigger acceptance until the idle gap completes
//   done_out    one-cycle pulse at the edge where the tail ends
//   state_out   current state encoding for debug
module diff_tx #(
    parameter int DATA_PERIOD               = 20,
    parameter int HALF_DATA_PERIOD          = 10,
    parameter int QUARTER_DATA_PERIOD       = 5,
    parameter int THREE_QUARTER_DATA_PERIOD = 15
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [25:0] code_in,
    input  logic        trigger_in,
    output logic        data_out,
    output logic        busy_out,
    output logic        done_out,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SL   = 3'd1,
        SH   = 3'd2,
        BL   = 3'd3,
        BH   = 3'd4,
        TAIL = 3'd5,
        GAP  = 3'd6
    } state_t;

    localparam int CW = $clog2(DATA_PERIOD + 1);

    // Counter holds "cycles remaining minus one" so a segment of N cycles
    // loads N-1 on entry and ends on the cycle the counter reads zero.
    localparam logic [CW-1:0] LD_FULL  = CW'(DATA_PERIOD - 1);
    localparam logic [CW-1:0] LD_HALF  = CW'(HALF_DATA_PERIOD - 1);
    localparam logic [CW-1:0] LD_SHORT = CW'(QUARTER_DATA_PERIOD - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(THREE_QUARTER_DATA_PERIOD - 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [4:0]     idx, idx_nxt;
    logic [25:0]    shreg, shreg_nxt;
    logic           data_nxt, busy_nxt, done_nxt;
    logic           seg_end;

    assign seg_end   = (cnt == '0);
    assign state_out = state;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= 5'd25;
            shreg    <= '0;
            data_out <= 1'b1;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idx      <= idx_nxt;
            shreg    <= shreg_nxt;
            data_out <= data_nxt;
            busy_out <= busy_nxt;
            done_out <= done_nxt;
        end
    end

    // The bit being sent always sits in shreg[25]; the register shifts left
    // at the end of each BH so the next bit moves into place.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = seg_end ? cnt : cnt - CW'(1);
        idx_nxt   = idx;
        shreg_nxt = shreg;
        data_nxt  = data_out;
        busy_nxt  = busy_out;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                data_nxt = 1'b1;
                busy_nxt = 1'b0;
                if (trigger_in) begin
                    state_nxt = SL;
                    shreg_nxt = code_in;
                    idx_nxt   = 5'd25;
                    cnt_nxt   = LD_HALF;
                    data_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            SL: begin
                if (seg_end) begin
                    state_nxt = SH;
                    cnt_nxt   = LD_HALF;
                    data_nxt  = 1'b1;
                end
            end
            SH: begin
                if (seg_end) begin
                    state_nxt = BL;
                    cnt_nxt   = shreg[25] ? LD_LONG : LD_SHORT;
                    data_nxt  = 1'b0;
                end
            end
            BL: begin
                if (seg_end) begin
                    state_nxt = BH;
                    cnt_nxt   = shreg[25] ? LD_SHORT : LD_LONG;
                    data_nxt  = 1'b1;
                end
            end
            BH: begin
                if (seg_end) begin
                    data_nxt = 1'b0;
                    if (idx == 5'd0) begin
                        state_nxt = TAIL;
                        cnt_nxt   = LD_HALF;
                    end else begin
                        state_nxt = BL;
                        idx_nxt   = idx - 5'd1;
                        shreg_nxt = {shreg[24:0], 1'b0};
                        cnt_nxt   = shreg[24] ? LD_LONG : LD_SHORT;
                    end
                end
            end
            TAIL: begin
                if (seg_end) begin
                    state_nxt = GAP;
                    cnt_nxt   = LD_FULL;
                    data_nxt  = 1'b1;
                    done_nxt  = 1'b1;
                end
            end
            GAP: begin
                if (seg_end) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                data_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_diff_tx.sv
// tb/tb_diff_tx.sv - self-checking bench for diff_tx with directed frames
module tb_diff_tx;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [25:0] code_in = '0;
    logic        trigger_in = 1'b0;
    logic        data_out;
    logic        busy_out;
    logic        done_out;
    logic [2:0]  state_out;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int NS = 600;
    int exp_data  [0:NS-1];
    int exp_state [0:NS-1];

    diff_tx dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .code_in    (code_in),
        .trigger_in (trigger_in),
        .data_out   (data_out),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .state_out  (state_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line/state per sample; sample j is taken after the j-th edge
    // following the trigger edge (j = 0 is the trigger edge itself).
    task automatic build(input logic [25:0] code);
        int n;
        n = 0;
        for (int k = 0; k < 10; k++) begin exp_data[n] = 0; exp_state[n] = 1; n++; end
        for (int k = 0; k < 10; k++) begin exp_data[n] = 1; exp_state[n] = 2; n++; end
        for (int i = 25; i >= 0; i--) begin
            for (int k = 0; k < (code[i] ? 15 : 5); k++) begin exp_data[n] = 0; exp_state[n] = 3; n++; end
            for (int k = 0; k < (code[i] ? 5 : 15); k++) begin exp_data[n] = 1; exp_state[n] = 4; n++; end
        end
        for (int k = 0; k < 10; k++) begin exp_data[n] = 0; exp_state[n] = 5; n++; end
        for (int k = 0; k < 20; k++) begin exp_data[n] = 1; exp_state[n] = 6; n++; end
        while (n < NS) begin exp_data[n] = 1; exp_state[n] = 0; n++; end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first IDLE cycle (sample 570) so a follow-on frame can trigger there.
    // abort_at >= 0 asserts reset at that sample and returns with reset held.
    task automatic run_frame(input logic [25:0] code, input bit intrude, input int abort_at);
        build(code);
        code_in    = code;
        trigger_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        trigger_in = 1'b0;
        for (int j = 0; j <= 570; j++) begin
            if (j > 0) @(negedge clk_in);
            if (j == 1) code_in = ~code;
            if (intrude && j == 300) begin code_in = 26'h1234567; trigger_in = 1'b1; end
            if (intrude && j == 301) trigger_in = 1'b0;
            if (j == abort_at) begin
                rst_n_in = 1'b0;
                #1;
                check("abort_data", {31'b0, data_out}, 32'd1);
                check("abort_busy", {31'b0, busy_out}, 32'd0);
                check("abort_done", {31'b0, done_out}, 32'd0);
                check("abort_state", {29'b0, state_out}, 32'd0);
                return;
            end
            check($sformatf("data@%0d", j), {31'b0, data_out}, 32'(exp_data[j]));
            check($sformatf("state@%0d", j), {29'b0, state_out}, 32'(exp_state[j]));
            check($sformatf("busy@%0d", j), {31'b0, busy_out}, (j < 570) ? 32'd1 : 32'd0);
            check($sformatf("done@%0d", j), {31'b0, done_out}, (j == 550) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        // Reset held: trigger must be ignored.
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        code_in    = 26'h3FFFFFF;
        trigger_in = 1'b1;
        @(negedge clk_in);
        check("rst_data", {31'b0, data_out}, 32'd1);
        check("rst_busy", {31'b0, busy_out}, 32'd0);
        check("rst_done", {31'b0, done_out}, 32'd0);
        check("rst_state", {29'b0, state_out}, 32'd0);
        trigger_in = 1'b0;
        rst_n_in   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            check("idle_data", {31'b0, data_out}, 32'd1);
            check("idle_busy", {31'b0, busy_out}, 32'd0);
        end

        run_frame(26'h0000000, 1'b0, -1);
        run_frame(26'h3FFFFFF, 1'b0, -1);
        // Back-to-back, each triggered in the first IDLE cycle.
        run_frame(26'h2AAAAAA, 1'b0, -1);
        run_frame(26'h1555555, 1'b0, -1);
        // Trigger while busy is ignored.
        run_frame(26'h0C3A5F1, 1'b1, -1);
        repeat (3) @(negedge clk_in);
        // Reset during BL of bit 12 (samples 280..284 for this code).
        run_frame(26'h0ABCDEF, 1'b0, 282);
        repeat (2) @(negedge clk_in);
        check("abort_hold_data", {31'b0, data_out}, 32'd1);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        run_frame(26'h0ABCDEF, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
